// File: rtl/shreg_pkg.sv
// ---------------------------------------------------------------------------
// shreg_pkg
// Shared definitions for the universal shift register.
//   mode_e : operation select carried on the mode bus of shreg_univ.
// ---------------------------------------------------------------------------
package shreg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage : shreg_pkg

// File: rtl/shreg_univ_if.sv
// ---------------------------------------------------------------------------
// shreg_univ_if
// Command/data bundle for shreg_univ. Clock and reset stay outside.
//   en, clk_en  : operation occurs only when both are high
//   mode        : 00 hold, 01 shift left, 10 shift right, 11 parallel load
//   sin         : serial input bit
//   pin         : parallel load data (WIDTH bits)
//   rot         : rotate instead of shifting in sin (only with SHREG_UNIV_ROT_EN)
//   q           : register contents
//   sout_l/_r   : q[WIDTH-1] / q[0]
//   cnt         : shifts since last load or wrap (CW bits)
//   co          : one-cycle pulse on counter wrap
// Modports: master drives commands (bench / upstream), slave is the register.
// Optional feature macro: SHREG_UNIV_ROT_EN
// ---------------------------------------------------------------------------
interface shreg_univ_if #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH)
);

  logic             en;
  logic             clk_en;
  logic [1:0]       mode;
  logic             sin;
  logic [WIDTH-1:0] pin;
`ifdef SHREG_UNIV_ROT_EN
  logic             rot;
`endif
  logic [WIDTH-1:0] q;
  logic             sout_l;
  logic             sout_r;
  logic [CW-1:0]    cnt;
  logic             co;

`ifdef SHREG_UNIV_ROT_EN
  modport master (output en, clk_en, mode, sin, pin, rot,
                  input  q, sout_l, sout_r, cnt, co);
  modport slave  (input  en, clk_en, mode, sin, pin, rot,
                  output q, sout_l, sout_r, cnt, co);
`else
  modport master (output en, clk_en, mode, sin, pin,
                  input  q, sout_l, sout_r, cnt, co);
  modport slave  (input  en, clk_en, mode, sin, pin,
                  output q, sout_l, sout_r, cnt, co);
`endif

endinterface : shreg_univ_if

// File: rtl/shift_cnt.sv
// ---------------------------------------------------------------------------
// shift_cnt
// Wrap counter that tracks shifts and pulses co for one cycle on wrap.
// Ports:
//   clk     in  rising-edge clock
//   rst     in  asynchronous active-low reset
//   en      in  operation enable
//   clk_en  in  clock-enable qualifier (counter acts only when en & clk_en)
//   inc     in  count one shift
//   clr     in  clear count (has priority over inc)
//   cnt     out current count, 0..MAX
//   co      out registered pulse, high the cycle after cnt wraps MAX -> 0
// ---------------------------------------------------------------------------
module shift_cnt #(
  parameter int MAX = 3,
  parameter int CW  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clk_en,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          co
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          co_q, co_d;
  logic          active;

  assign active = en & clk_en;

  // co defaults low so it can never stay high past one cycle.
  always_comb begin
    cnt_d = cnt_q;
    co_d  = 1'b0;
    if (active) begin
      if (clr) begin
        cnt_d = '0;
      end else if (inc) begin
        if (cnt_q == CW'(MAX)) begin
          cnt_d = '0;
          co_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      co_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      co_q  <= co_d;
    end
  end

  assign cnt = cnt_q;
  assign co  = co_q;

endmodule : shift_cnt

// File: rtl/shreg_univ.sv
// ---------------------------------------------------------------------------
// shreg_univ
// Parametrised universal shift register: hold, shift left, shift right and
// parallel load, with an integrated shift counter that pulses co once every
// WIDTH shifts.
// Ports:
//   clk   in  rising-edge clock
//   rst   in  asynchronous active-low reset (clears q, cnt, co)
//   bus   shreg_univ_if.slave : en, clk_en, mode, sin, pin, [rot] in;
//                               q, sout_l, sout_r, cnt, co out
// Parameters: WIDTH (2..32); CW = $clog2(WIDTH) is derived.
// Optional feature macro: SHREG_UNIV_ROT_EN (adds rot: shifts rotate and
// ignore sin while rot=1).
// ---------------------------------------------------------------------------
module shreg_univ
  import shreg_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic         clk,
  input  logic         rst,
  shreg_univ_if.slave  bus
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             active;
  logic             fill_l;
  logic             fill_r;
  logic             is_shift;
  logic             is_load;

  assign active   = bus.en & bus.clk_en;
  assign is_shift = (bus.mode == MODE_SHL) || (bus.mode == MODE_SHR);
  assign is_load  = (bus.mode == MODE_LOAD);

  // Bit entering the vacated position: serial input, or the bit falling
  // off the opposite end when rotating.
`ifdef SHREG_UNIV_ROT_EN
  assign fill_l = bus.rot ? q_q[WIDTH-1] : bus.sin;
  assign fill_r = bus.rot ? q_q[0]       : bus.sin;
`else
  assign fill_l = bus.sin;
  assign fill_r = bus.sin;
`endif

  always_comb begin
    q_d = q_q;
    if (active) begin
      case (bus.mode)
        MODE_SHL:  q_d = {q_q[WIDTH-2:0], fill_l};
        MODE_SHR:  q_d = {fill_r, q_q[WIDTH-1:1]};
        MODE_LOAD: q_d = bus.pin;
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Load clears the count and wins over a wrap that would otherwise fire.
  shift_cnt #(
    .MAX (WIDTH - 1),
    .CW  (CW)
  ) u_shift_cnt (
    .clk    (clk),
    .rst    (rst),
    .en     (bus.en),
    .clk_en (bus.clk_en),
    .inc    (is_shift),
    .clr    (is_load),
    .cnt    (bus.cnt),
    .co     (bus.co)
  );

  assign bus.q      = q_q;
  assign bus.sout_l = q_q[WIDTH-1];
  assign bus.sout_r = q_q[0];

endmodule : shreg_univ

// File: tb/tb_shreg_univ.sv
// ---------------------------------------------------------------------------
// tb_shreg_univ
// Drives a WIDTH=4 and a WIDTH=5 instance from one directed sequence followed
// by random traffic; a value-level model (integers, modulo counting) tracks
// the expected register, count and wrap pulse for each instance.
// Optional feature macro: SHREG_UNIV_ROT_EN (enables the rotate steps).
// ---------------------------------------------------------------------------
module tb_shreg_univ;
  import shreg_pkg::*;

  logic clk;
  logic rst;

  shreg_univ_if #(.WIDTH(4)) b4 ();
  shreg_univ_if #(.WIDTH(5)) b5 ();

  shreg_univ #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));
  shreg_univ #(.WIDTH(5)) u_dut5 (.clk(clk), .rst(rst), .bus(b5));

  bit rot_v [2];
`ifdef SHREG_UNIV_ROT_EN
  assign b4.rot = rot_v[0];
  assign b5.rot = rot_v[1];
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed values, zero-extended, indexed by instance.
  logic [31:0] oq   [2];
  logic [31:0] ocnt [2];
  logic        oco  [2];
  logic        osl  [2];
  logic        osr  [2];
  assign oq[0]   = 32'(b4.q);
  assign oq[1]   = 32'(b5.q);
  assign ocnt[0] = 32'(b4.cnt);
  assign ocnt[1] = 32'(b5.cnt);
  assign oco[0]  = b4.co;
  assign oco[1]  = b5.co;
  assign osl[0]  = b4.sout_l;
  assign osl[1]  = b5.sout_l;
  assign osr[0]  = b4.sout_r;
  assign osr[1]  = b5.sout_r;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int unsigned wv   [2] = '{4, 5};
  int unsigned mq   [2];
  int unsigned mcnt [2];
  bit          mco  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_rst();
    for (int i = 0; i < 2; i++) begin
      mq[i] = 0; mcnt[i] = 0; mco[i] = 1'b0;
    end
  endtask

  // One active clock edge of the behaviour described for the register.
  task automatic model_edge(input int i, input bit en, input bit ce, input logic [1:0] md,
                            input bit s, input logic [31:0] p, input bit rt);
    int unsigned w    = wv[i];
    int unsigned mask = (32'd1 << w) - 1;
    int unsigned in_l, in_r;
    mco[i] = 1'b0;
    if (!(en && ce) || md == 2'b00) return;
    if (md == 2'b11) begin
      mq[i]   = p & mask;
      mcnt[i] = 0;
      return;
    end
    in_l = rt ? ((mq[i] >> (w - 1)) & 1) : 32'(s);
    in_r = rt ? (mq[i] & 1) : 32'(s);
    if (md == 2'b01) mq[i] = ((mq[i] << 1) | in_l) & mask;
    else             mq[i] = (mq[i] >> 1) | (in_r << (w - 1));
    mcnt[i] = (mcnt[i] + 1) % w;
    mco[i]  = (mcnt[i] == 0);
  endtask

  task automatic drv(input int i, input bit en, input bit ce, input logic [1:0] md,
                     input bit s, input logic [31:0] p);
    if (i == 0) begin
      b4.en = en; b4.clk_en = ce; b4.mode = md; b4.sin = s; b4.pin = p[3:0];
    end else begin
      b5.en = en; b5.clk_en = ce; b5.mode = md; b5.sin = s; b5.pin = p[4:0];
    end
  endtask

  task automatic step();
    model_edge(0, b4.en, b4.clk_en, b4.mode, b4.sin, 32'(b4.pin), rot_v[0]);
    model_edge(1, b5.en, b5.clk_en, b5.mode, b5.sin, 32'(b5.pin), rot_v[1]);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int i, input string tag);
    chk($sformatf("%s_q%0d", tag, i),      oq[i],          32'(mq[i]));
    chk($sformatf("%s_cnt%0d", tag, i),    ocnt[i],        32'(mcnt[i]));
    chk($sformatf("%s_co%0d", tag, i),     32'(oco[i]),    32'(mco[i]));
    chk($sformatf("%s_soutl%0d", tag, i),  32'(osl[i]),    (mq[i] >> (wv[i] - 1)) & 1);
    chk($sformatf("%s_soutr%0d", tag, i),  32'(osr[i]),    mq[i] & 1);
  endtask

  initial begin
    int          pulses;
    logic [31:0] saved_q, saved_cnt;
    bit          seq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    rst = 1'b0;
    drv(0, 0, 0, MODE_HOLD, 0, 0);
    drv(1, 0, 0, MODE_HOLD, 0, 0);
    model_rst();
    #3;
    check_all(0, "por");
    check_all(1, "por");
    @(negedge clk);
    rst = 1'b1;

    // Asynchronous reset mid-cycle discards a loaded value and a partial count.
    drv(0, 1, 1, MODE_LOAD, 0, 32'hA);
    step();
    chk("load_a_q", oq[0], 32'hA);
    drv(0, 1, 1, MODE_SHL, 1, 0);
    step();
    check_all(0, "pre_rst");
    drv(0, 0, 0, MODE_HOLD, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    model_rst();
    chk("async_rst_q", oq[0], 32'h0);
    chk("async_rst_cnt", ocnt[0], 32'h0);
    chk("async_rst_co", 32'(oco[0]), 32'h0);
    #1;
    rst = 1'b1;

    // Shift left 1,0,1,1: wrap pulse after the fourth shift.
    for (int k = 0; k < 4; k++) begin
      drv(0, 1, 1, MODE_SHL, seq[k], 0);
      step();
      check_all(0, "shl");
    end
    chk("shl_q_1011", oq[0], 32'hB);
    chk("shl_co_wrap", 32'(oco[0]), 32'h1);
    chk("shl_cnt_wrap", ocnt[0], 32'h0);
    drv(0, 1, 1, MODE_HOLD, 1, 0);
    step();
    chk("shl_co_drop", 32'(oco[0]), 32'h0);

    // Shift right from 0110 with sin=0 twice.
    drv(0, 1, 1, MODE_LOAD, 0, 32'h6);
    step();
    drv(0, 1, 1, MODE_SHR, 0, 0);
    step();
    step();
    check_all(0, "shr");
    chk("shr_q_0001", oq[0], 32'h1);
    chk("shr_soutr", 32'(osr[0]), 32'h1);
    chk("shr_cnt2", ocnt[0], 32'h2);
    chk("shr_co0", 32'(oco[0]), 32'h0);

    // clk_en toggling: 8 edges, 4 shifts, one pulse.
    drv(0, 1, 1, MODE_LOAD, 0, 32'h0);
    step();
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      drv(0, 1, (k % 2) == 0, MODE_SHL, 1'($urandom), 0);
      step();
      check_all(0, "gate");
      pulses += int'(oco[0]);
    end
    chk("gate_pulses", 32'(pulses), 32'h1);
    saved_q   = oq[0];
    saved_cnt = ocnt[0];
    drv(0, 1, 1, MODE_HOLD, 1, 32'h5);
    step();
    step();
    chk("hold_q", oq[0], saved_q);
    chk("hold_cnt", ocnt[0], saved_cnt);
    check_all(0, "hold");

    // WIDTH=5: load collides with a pending wrap, then a full 5-shift cycle.
    drv(0, 0, 0, MODE_HOLD, 0, 0);
    drv(1, 1, 1, MODE_LOAD, 0, 32'h0);
    step();
    for (int k = 0; k < 4; k++) begin
      drv(1, 1, 1, MODE_SHR, 1'($urandom), 0);
      step();
    end
    chk("w5_cnt4", ocnt[1], 32'h4);
    drv(1, 1, 1, MODE_LOAD, 0, 32'h1F);
    step();
    chk("w5_load_q", oq[1], 32'h1F);
    chk("w5_load_cnt", ocnt[1], 32'h0);
    chk("w5_load_co", 32'(oco[1]), 32'h0);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      drv(1, 1, 1, (k % 2) ? MODE_SHR : MODE_SHL, 1'($urandom), 0);
      step();
      check_all(1, "w5");
      pulses += int'(oco[1]);
    end
    chk("w5_pulses", 32'(pulses), 32'h1);
    chk("w5_cnt_wrap", ocnt[1], 32'h0);
    drv(1, 0, 0, MODE_HOLD, 0, 0);

`ifdef SHREG_UNIV_ROT_EN
    // Rotation ignores sin.
    drv(0, 1, 1, MODE_LOAD, 0, 32'h9);
    step();
    rot_v[0] = 1'b1;
    drv(0, 1, 1, MODE_SHL, 0, 0);
    step();
    chk("rot_l", oq[0], 32'h3);
    drv(0, 1, 1, MODE_SHR, 1, 0);
    step();
    step();
    chk("rot_r", oq[0], 32'hC);
    check_all(0, "rot");
    rot_v[0] = 1'b0;
`endif

    // Random traffic on both instances with occasional asynchronous reset.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 2; i++) begin
        drv(i, $urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0,
            2'($urandom), 1'($urandom), $urandom);
`ifdef SHREG_UNIV_ROT_EN
        rot_v[i] = 1'($urandom);
`endif
      end
      step();
      check_all(0, "rnd");
      check_all(1, "rnd");
      if ($urandom_range(0, 39) == 0) begin
        #2;
        rst = 1'b0;
        #1;
        model_rst();
        check_all(0, "rnd_rst");
        check_all(1, "rnd_rst");
        #1;
        rst = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_shreg_univ
